// File: rtl/timer_sequencer.sv
// timer_sequencer: drives a timer slave through program/start, irq service and stop from a command port.
// Ports: clk, reset_n (async, active-low); cmd_start/cmd_period/cmd_continuous/cmd_stop/cmd_ready command side;
// tick/tick_count service status; t_address/t_chipselect/t_write_n/t_writedata/t_readdata/t_irq timer slave bus.
// Define TIMER_SEQUENCER_SNAPSHOT_EN to add snap_req/snap_valid/snap_value counter snapshot support.
module timer_sequencer #(
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_start,
  input  logic [31:0]       cmd_period,
  input  logic              cmd_continuous,
  input  logic              cmd_stop,
  output logic              cmd_ready,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [2:0]        t_address,
  output logic              t_chipselect,
  output logic              t_write_n,
  output logic [15:0]       t_writedata,
  input  logic [15:0]       t_readdata,
  input  logic              t_irq
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
  ,
  input  logic              snap_req,
  output logic              snap_valid,
  output logic [31:0]       snap_value
`endif
);
  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTL, RUN, CLR_ST, WR_STOP
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
    , SNAP_WR, SNAP_RDL, SNAP_RDH, SNAP_CAP
`endif
  } state_t;
  state_t      state;
  logic [31:0] period;
  logic        cont;
  logic        stop_pending;
`ifndef TIMER_SEQUENCER_SNAPSHOT_EN
  logic unused_readdata;
  assign unused_readdata = ^t_readdata;
`endif
  assign cmd_ready = state == IDLE;
  assign tick      = state == CLR_ST;
  // bus fields are a pure decode of the state register so no input reaches the bus combinationally
  always_comb begin
    t_chipselect = 1'b1;
    t_write_n    = 1'b0;
    t_address    = 3'd0;
    t_writedata  = 16'h0000;
    case (state)
      WR_PL:   begin t_address = 3'd2; t_writedata = period[15:0]; end
      WR_PH:   begin t_address = 3'd3; t_writedata = period[31:16]; end
      WR_CTL:  begin t_address = 3'd1; t_writedata = {12'd0, 1'b0, 1'b1, cont, 1'b1}; end
      CLR_ST:  t_address = 3'd0;
      WR_STOP: begin t_address = 3'd1; t_writedata = 16'h0008; end
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
      SNAP_WR:  t_address = 3'd4;
      SNAP_RDL: begin t_address = 3'd4; t_write_n = 1'b1; end
      SNAP_RDH: begin t_address = 3'd5; t_write_n = 1'b1; end
`endif
      default: begin t_chipselect = 1'b0; t_write_n = 1'b1; end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      period       <= 32'd0;
      cont         <= 1'b0;
      stop_pending <= 1'b0;
      tick_count   <= '0;
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
      snap_valid   <= 1'b0;
      snap_value   <= 32'd0;
`endif
    end else begin
      stop_pending <= stop_pending | cmd_stop;
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
      snap_valid   <= state == SNAP_CAP;
`endif
      case (state)
        IDLE: begin
          stop_pending <= 1'b0;
          if (cmd_start) begin
            period     <= cmd_period == 32'd0 ? 32'd1 : cmd_period;
            cont       <= cmd_continuous;
            tick_count <= '0;
            state      <= WR_PL;
          end
        end
        WR_PL:  state <= WR_PH;
        WR_PH:  state <= WR_CTL;
        WR_CTL: state <= RUN;
        // a pending timeout always wins over a stop so its tick is never lost
        RUN: state <= t_irq ? CLR_ST : stop_pending ? WR_STOP :
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
                      snap_req ? SNAP_WR :
`endif
                      RUN;
        CLR_ST: begin
          tick_count <= tick_count + 1'b1;
          state      <= stop_pending ? WR_STOP : cont ? RUN : IDLE;
          if (!stop_pending && !cont) stop_pending <= 1'b0;
        end
        WR_STOP: begin
          stop_pending <= 1'b0;
          state        <= IDLE;
        end
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
        SNAP_WR:  state <= SNAP_RDL;
        SNAP_RDL: state <= SNAP_RDH;
        // read data lags the read by one cycle, so each half lands one state later
        SNAP_RDH: begin
          snap_value[15:0] <= t_readdata;
          state            <= SNAP_CAP;
        end
        SNAP_CAP: begin
          snap_value[31:16] <= t_readdata;
          state             <= RUN;
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: randomized scoreboard bench for timer_sequencer
module tb_timer_sequencer;
  localparam int TW = 8;
  logic clk = 1'b0, reset_n = 1'b0;
  logic cmd_start = 1'b0, cmd_continuous = 1'b0, cmd_stop = 1'b0, t_irq = 1'b0;
  logic [31:0] cmd_period = 32'd0;
  logic cmd_ready, tick, t_chipselect, t_write_n;
  logic [TW-1:0] tick_count;
  logic [2:0] t_address;
  logic [15:0] t_writedata;
  logic [15:0] t_readdata = 16'h0;
  logic [15:0] rd_lo = 16'h1234, rd_hi = 16'h0005;
  int checks = 0, passes = 0;
  logic [18:0] wr_q[$];
  logic [TW-1:0] tk_q[$];
  logic tc_chk = 1'b0;
  logic [TW-1:0] tc_exp;
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
  logic snap_req = 1'b0, snap_valid;
  logic [31:0] snap_value;
`endif
  timer_sequencer #(.TICK_W(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_start(cmd_start), .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
    .cmd_stop(cmd_stop), .cmd_ready(cmd_ready), .tick(tick), .tick_count(tick_count),
    .t_address(t_address), .t_chipselect(t_chipselect), .t_write_n(t_write_n),
    .t_writedata(t_writedata), .t_readdata(t_readdata), .t_irq(t_irq)
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
    , .snap_req(snap_req), .snap_valid(snap_valid), .snap_value(snap_value)
`endif
  );
  always #5 clk = ~clk;
  // timer slave read port: registered data, one cycle after the read
  always @(posedge clk)
    t_readdata <= (t_chipselect && t_write_n && t_address == 3'd4) ? rd_lo :
                  (t_chipselect && t_write_n && t_address == 3'd5) ? rd_hi : 16'hDEAD;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask
  // monitor: every bus write and tick must match the next queued expectation
  always @(negedge clk) if (reset_n) begin
    if (tc_chk) begin
      chk("tick_count_after_tick", tick_count, tc_exp);
      tc_chk = 1'b0;
    end
    if (t_chipselect && !t_write_n) begin
      if (wr_q.size() == 0) begin
        checks++;
        $display("FAIL spurious_write: got addr %0d data 0x%0h expected no write at %0t", t_address, t_writedata, $time);
      end else chk("bus_write", {t_address, t_writedata}, wr_q.pop_front());
    end
    if (!t_chipselect) chk("bus_idle", {t_write_n, t_address, t_writedata}, {1'b1, 19'd0});
    if (tick) begin
      if (tk_q.size() == 0) begin
        checks++;
        $display("FAIL spurious_tick: got tick=1 expected 0 at %0t", $time);
      end else begin
        tc_exp = tk_q.pop_front();
        tc_chk = 1'b1;
      end
    end
  end
  task automatic wait_ready();
    int i = 0;
    while (!cmd_ready && i < 50) begin @(negedge clk); i++; end
    chk("cmd_ready", cmd_ready, 1);
  endtask
  task automatic wait_tick();
    int i = 0;
    while (!tick && i < 50) begin @(negedge clk); i++; end
    chk("tick_seen", tick, 1);
  endtask
  // reference: start issues three writes, each serviced irq one clear write and a count step,
  // and a stop taken while running issues the stop write
  task automatic run_txn(input logic [31:0] p, input logic c, input int nirq, input int smode, input logic seq);
    logic [31:0] pe;
    logic [15:0] ctl;
    logic [TW-1:0] cnt;
    cnt = '0;
    pe = (p == 32'd0) ? 32'd1 : p;
    ctl = c ? 16'h0007 : 16'h0005;
    wait_ready();
    wr_q.push_back({3'd2, pe[15:0]});
    wr_q.push_back({3'd3, pe[31:16]});
    wr_q.push_back({3'd1, ctl});
    cmd_start = 1'b1; cmd_period = p; cmd_continuous = c;
    @(negedge clk);
    cmd_start = 1'b0; cmd_period = $urandom; cmd_continuous = 1'($urandom);
    if (seq) begin
      chk("seq_period_lo", {t_chipselect, t_write_n, t_address, t_writedata}, {2'b10, 3'd2, pe[15:0]});
      @(negedge clk);
      chk("seq_period_hi", {t_chipselect, t_write_n, t_address, t_writedata}, {2'b10, 3'd3, pe[31:16]});
      @(negedge clk);
      chk("seq_control", {t_chipselect, t_write_n, t_address, t_writedata}, {2'b10, 3'd1, ctl});
      @(negedge clk);
      chk("seq_run", {t_chipselect, cmd_ready}, 0);
    end
    for (int i = 0; i < nirq; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      cnt = cnt + 1'b1;
      wr_q.push_back({3'd0, 16'h0000});
      tk_q.push_back(cnt);
      t_irq = 1'b1;
      if (i == nirq - 1 && smode == 1) begin
        wr_q.push_back({3'd1, 16'h0008});
        cmd_stop = 1'b1;
      end
      @(negedge clk);
      cmd_stop = 1'b0;
      wait_tick();
      t_irq = 1'b0;
    end
    if (smode == 2) begin
      @(negedge clk);
      if (c) begin
        cmd_start = 1'b1; cmd_period = $urandom;
        @(negedge clk);
        cmd_start = 1'b0;
        wr_q.push_back({3'd1, 16'h0008});
      end
      cmd_stop = 1'b1;
      @(negedge clk);
      cmd_stop = 1'b0;
    end
    wait_ready();
    chk("final_tick_count", tick_count, cnt);
  endtask
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
  task automatic snap_once(input logic [15:0] lo, input logic [15:0] hi);
    int i = 0;
    rd_lo = lo; rd_hi = hi;
    wr_q.push_back({3'd4, 16'h0000});
    snap_req = 1'b1;
    while (!snap_valid && i < 20) begin @(negedge clk); i++; end
    snap_req = 1'b0;
    chk("snap_valid_hi", snap_valid, 1);
    chk("snap_value", snap_value, {hi, lo});
    @(negedge clk);
    chk("snap_valid_pulse", snap_valid, 0);
  endtask
`endif
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #1;
    chk("reset_ready", cmd_ready, 1);
    chk("reset_tick", tick, 0);
    chk("reset_count", tick_count, 0);
    chk("reset_bus", {t_chipselect, t_write_n, t_address, t_writedata}, {2'b01, 19'd0});
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_txn(32'h000186A0, 1'b1, 2, 1, 1'b1);
    run_txn(32'd5, 1'b0, 1, 0, 1'b0);
    run_txn(32'd0, 1'b0, 1, 2, 1'b1);
    run_txn($urandom, 1'b1, 257, 2, 1'b0);
    wait_ready();
    wr_q.push_back({3'd2, 16'h0042});
    wr_q.push_back({3'd3, 16'h0000});
    cmd_start = 1'b1; cmd_period = 32'h42; cmd_continuous = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_cs", t_chipselect, 0);
    chk("midreset_ready", cmd_ready, 1);
    chk("midreset_tick", tick, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midreset_no_ctl", wr_q.size(), 0);
    chk("midreset_idle", cmd_ready, 1);
`ifdef TIMER_SEQUENCER_SNAPSHOT_EN
    wr_q.push_back({3'd2, 16'h0010});
    wr_q.push_back({3'd3, 16'h0000});
    wr_q.push_back({3'd1, 16'h0007});
    cmd_start = 1'b1; cmd_period = 32'h10; cmd_continuous = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (4) @(negedge clk);
    snap_once(16'h1234, 16'h0005);
    @(negedge clk);
    snap_once(16'($urandom), 16'($urandom));
    wr_q.push_back({3'd1, 16'h0008});
    cmd_stop = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0;
    wait_ready();
`endif
    for (int n = 0; n < 20; n++) begin
      logic c;
      c = 1'($urandom);
      run_txn(($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, c, c ? int'($urandom_range(1, 4)) : 1,
              c ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2)), 1'($urandom));
    end
    repeat (3) @(negedge clk);
    chk("write_queue_drained", wr_q.size(), 0);
    chk("tick_queue_drained", tk_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
